// File: rtl/uart_ram_arbiter.sv
// Shares one single-port byte RAM between NCH receive writers and NCH transmit readers,
// one circular buffer per channel. Optional macro UART_RAM_ARBITER_DROP_EN drops bytes into full buffers.
module uart_ram_arbiter #(
    parameter int NCH       = 10,
    parameter int REGION_AW = 10,
    parameter int AW        = $clog2(NCH) + REGION_AW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH-1:0]       i_wreq,
    input  logic [8*NCH-1:0]     i_wdata,
    output logic [NCH-1:0]       o_wack,
    input  logic [NCH-1:0]       i_rreq,
    output logic [NCH-1:0]       o_rvalid,
    output logic [7:0]           o_rdata,
    output logic [NCH-1:0]       o_empty,
    output logic [NCH-1:0]       o_full,
    output logic [NCH-1:0]       o_ovf,
    output logic [AW-1:0]        o_addr,
    output logic [7:0]           o_D,
    input  logic [7:0]           i_D,
    output logic                 o_we,
    output logic                 o_re,
    output logic [2:0]           o_dbg_state
);

    localparam int CW   = $clog2(NCH);
    localparam int CNTW = REGION_AW + 1;
    localparam logic [CNTW-1:0]      CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0]      CNT_FULL = {1'b1, {REGION_AW{1'b0}}};
    localparam logic [REGION_AW-1:0] PTR_ONE  = REGION_AW'(1);

    typedef enum logic [2:0] {ARB_W, WRITE, ARB_R, READ, RDATA} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_ch;
    logic [7:0]            r_byte;
    logic [CW-1:0]         r_wlast;
    logic [CW-1:0]         r_rlast;
    logic [REGION_AW-1:0]  r_wptr  [NCH];
    logic [REGION_AW-1:0]  r_rptr  [NCH];
    logic [CNTW-1:0]       r_count [NCH];
    logic [NCH-1:0]        w_full;
    logic [NCH-1:0]        w_empty;
    logic [NCH-1:0]        w_welig;
    logic [NCH-1:0]        w_relig;
    logic [CW:0]           w_wpick;
    logic [CW:0]           w_rpick;
    logic                  w_drop;

    // Returns {found, index} of the first eligible channel after 'last', wrapping modulo NCH.
    function automatic logic [CW:0] rr_pick(input logic [NCH-1:0] elig, input logic [CW-1:0] last);
        logic [CW:0] k;
        logic [CW:0] res;
        res = '0;
        for (int i = NCH; i >= 1; i--) begin
            k = {1'b0, last} + (CW+1)'(i);
            if (k >= (CW+1)'(NCH)) k = k - (CW+1)'(NCH);
            if (elig[k[CW-1:0]]) res = {1'b1, k[CW-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        w_full  = '0;
        w_empty = '0;
        for (int c = 0; c < NCH; c++) begin
            w_full[c]  = (r_count[c] == CNT_FULL);
            w_empty[c] = (r_count[c] == '0);
        end
    end

    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign w_relig     = i_rreq & ~w_empty;
    assign w_wpick     = rr_pick(w_welig, r_wlast);
    assign w_rpick     = rr_pick(w_relig, r_rlast);
    assign o_dbg_state = r_state;

`ifdef UART_RAM_ARBITER_DROP_EN
    logic [NCH-1:0] r_ovf;

    // Full receivers still win grants so they never stall; their byte is discarded.
    assign w_welig = i_wreq;
    assign w_drop  = w_full[r_ch];
    assign o_ovf   = r_ovf;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ovf <= '0;
        end else if (r_state == WRITE && w_drop) begin
            r_ovf[r_ch] <= 1'b1;
        end
    end
`else
    assign w_welig = i_wreq & ~w_full;
    assign w_drop  = 1'b0;
    assign o_ovf   = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ARB_W;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        o_we     = 1'b0;
        o_re     = 1'b0;
        o_wack   = '0;
        o_rvalid = '0;
        o_addr   = '0;
        o_D      = '0;
        o_rdata  = '0;
        case (r_state)
            ARB_W: w_next = w_wpick[CW] ? WRITE : ARB_R;
            WRITE: begin
                o_wack[r_ch] = 1'b1;
                if (!w_drop) begin
                    o_we   = 1'b1;
                    o_addr = {r_ch, r_wptr[r_ch]};
                    o_D    = r_byte;
                end
                w_next = ARB_R;
            end
            ARB_R: w_next = w_rpick[CW] ? READ : ARB_W;
            READ: begin
                o_re   = 1'b1;
                o_addr = {r_ch, r_rptr[r_ch]};
                w_next = RDATA;
            end
            RDATA: begin
                o_rvalid[r_ch] = 1'b1;
                o_rdata        = i_D;
                w_next         = ARB_W;
            end
            default: w_next = ARB_W;
        endcase
    end

    // Pointers are REGION_AW bits wide, so increments wrap inside the channel region.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ch    <= '0;
            r_byte  <= '0;
            r_wlast <= CW'(NCH-1);
            r_rlast <= CW'(NCH-1);
            for (int c = 0; c < NCH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
        end else begin
            case (r_state)
                ARB_W: if (w_wpick[CW]) begin
                    r_ch    <= w_wpick[CW-1:0];
                    r_byte  <= i_wdata[8*w_wpick[CW-1:0] +: 8];
                    r_wlast <= w_wpick[CW-1:0];
                end
                WRITE: if (!w_drop) begin
                    r_wptr[r_ch]  <= r_wptr[r_ch] + PTR_ONE;
                    r_count[r_ch] <= r_count[r_ch] + CNT_ONE;
                end
                ARB_R: if (w_rpick[CW]) begin
                    r_ch    <= w_rpick[CW-1:0];
                    r_rlast <= w_rpick[CW-1:0];
                end
                READ: begin
                    r_rptr[r_ch]  <= r_rptr[r_ch] + PTR_ONE;
                    r_count[r_ch] <= r_count[r_ch] - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Bench for uart_ram_arbiter: directed steps plus random traffic checked against per-channel byte queues.
// Also covers the UART_RAM_ARBITER_DROP_EN build when that macro is defined.
module tb_uart_ram_arbiter;

    localparam int NCH = 10;
    localparam int RAW = 10;
    localparam int AW  = 14;
    localparam int DEPTH = 1 << RAW;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [NCH-1:0]     i_wreq = '0;
    logic [8*NCH-1:0]   i_wdata = '0;
    logic [NCH-1:0]     i_rreq = '0;
    logic [7:0]         i_D = '0;
    logic [NCH-1:0]     o_wack, o_rvalid, o_empty, o_full, o_ovf;
    logic [7:0]         o_rdata, o_D;
    logic [AW-1:0]      o_addr;
    logic               o_we, o_re;
    logic [2:0]         o_dbg_state;

    uart_ram_arbiter #(.NCH(NCH), .REGION_AW(RAW), .AW(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_wreq(i_wreq), .i_wdata(i_wdata), .o_wack(o_wack),
        .i_rreq(i_rreq), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_empty(o_empty),
        .o_full(o_full), .o_ovf(o_ovf), .o_addr(o_addr), .o_D(o_D), .i_D(i_D),
        .o_we(o_we), .o_re(o_re), .o_dbg_state(o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural single-port RAM: read data appears one cycle after o_re.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge i_clk) begin
        if (o_we) mem[o_addr] <= o_D;
        if (o_re) i_D <= mem[o_addr];
    end

    // Reference model: per-channel byte queues and transaction counters.
    logic [7:0]     exp_q [NCH][$];
    int             wcnt [NCH];
    int             rcnt [NCH];
    int             mcount [NCH];
    int             wlast_m, rlast_m, pend_rd;
    bit             rd_due, mon_en;
    logic [NCH-1:0] ovf_m, welig_p, relig_p;
    int             tests = 0, fails = 0, n_wr = 0, n_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            wcnt[c] = 0; rcnt[c] = 0; mcount[c] = 0;
        end
        wlast_m = NCH-1; rlast_m = NCH-1; pend_rd = -1; rd_due = 0; ovf_m = '0;
    endtask

    task automatic monitor();
        logic [NCH-1:0] e_empty, e_full;
        int c, ns;
        for (int k = 0; k < NCH; k++) begin
            e_empty[k] = (mcount[k] == 0);
            e_full[k]  = (mcount[k] == DEPTH);
        end
        chk("empty", o_empty, e_empty);
        chk("full", o_full, e_full);
        chk("ovf", o_ovf, ovf_m);
        ns = ((o_we || o_wack != 0) ? 1 : 0) + (o_re ? 1 : 0) + ((o_rvalid != 0) ? 1 : 0);
        chk("slot_excl", (ns <= 1), 1);
        chk("wack_onehot", $onehot0(o_wack), 1);
        chk("rvalid_onehot", $onehot0(o_rvalid), 1);
        if (rd_due) begin
            chk("rvalid_due", (o_rvalid != 0), 1);
            c = first_idx(o_rvalid);
            chk("rvalid_ch", c, pend_rd);
            if (c >= 0) chk("rdata", o_rdata, (exp_q[c].size() > 0) ? exp_q[c].pop_front() : 32'h100);
            n_rd++;
            rd_due = 0;
        end else begin
            chk("rvalid_stray", o_rvalid, 0);
        end
        if (o_wack != 0) begin
            c = first_idx(o_wack);
            chk("w_elig", welig_p[c], 1);
            for (int k = (wlast_m + 1) % NCH; k != c; k = (k + 1) % NCH) chk("w_rr_skip", welig_p[k], 0);
            if (mcount[c] == DEPTH) begin
                chk("w_drop_we", o_we, 0);
                ovf_m[c] = 1'b1;
            end else begin
                chk("we", o_we, 1);
                chk("w_addr", o_addr, c*DEPTH + wcnt[c] % DEPTH);
                chk("w_data", o_D, i_wdata[8*c +: 8]);
                exp_q[c].push_back(i_wdata[8*c +: 8]);
                wcnt[c]++; mcount[c]++; n_wr++;
            end
            wlast_m = c;
            i_wdata[8*c +: 8] = 8'($urandom);
        end else begin
            chk("we_idle", o_we, 0);
        end
        if (o_re) begin
            c = int'(o_addr[AW-1:RAW]);
            chk("r_ch_range", (c < NCH), 1);
            if (c < NCH) begin
                chk("r_elig", relig_p[c], 1);
                for (int k = (rlast_m + 1) % NCH; k != c; k = (k + 1) % NCH) chk("r_rr_skip", relig_p[k], 0);
                chk("r_addr", o_addr[RAW-1:0], rcnt[c] % DEPTH);
                rcnt[c]++; mcount[c]--;
                rlast_m = c; pend_rd = c; rd_due = 1;
            end
        end
    endtask

    task automatic tick();
        for (int c = 0; c < NCH; c++) begin
`ifdef UART_RAM_ARBITER_DROP_EN
            welig_p[c] = i_wreq[c];
`else
            welig_p[c] = i_wreq[c] && (mcount[c] != DEPTH);
`endif
            relig_p[c] = i_rreq[c] && (mcount[c] != 0);
        end
        @(negedge i_clk);
        if (mon_en) monitor();
    endtask

    task automatic do_reset();
        mon_en = 0;
        i_rst = 1'b0; i_wreq = '0; i_rreq = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        mon_en = 1;
    endtask

    task automatic wait_wack(output int ch, output int n);
        ch = -1; n = 0;
        while (ch < 0 && n < 20) begin
            tick(); n++;
            if (o_wack != 0) ch = first_idx(o_wack);
        end
        chk("wack_timeout", (ch >= 0), 1);
    endtask

    task automatic wait_re(output int n);
        bit seen;
        seen = 0; n = 0;
        while (!seen && n < 20) begin
            tick(); n++;
            seen = o_re;
        end
        chk("re_timeout", seen, 1);
    endtask

    int ch, n, cnt;

    initial begin
        model_reset();
        for (int c = 0; c < NCH; c++) i_wdata[8*c +: 8] = 8'($urandom);

        // Reset values just after release.
        do_reset();
        chk("rst_empty", o_empty, 10'h3FF);
        chk("rst_full", o_full, 0);
        chk("rst_we", o_we, 0);
        chk("rst_re", o_re, 0);
        chk("rst_wack", o_wack, 0);
        chk("rst_rvalid", o_rvalid, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_D", o_D, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_ovf", o_ovf, 0);

        // Single byte through channel 3 with exact latencies.
        i_wreq[3] = 1'b1;
        i_wdata[8*3 +: 8] = 8'hA5;
        tick();
        chk("c3_wack", o_wack, 10'h008);
        chk("c3_we", o_we, 1);
        chk("c3_waddr", o_addr, 3072);
        chk("c3_D", o_D, 8'hA5);
        i_wreq = '0;
        tick();
        chk("c3_wack_1cyc", o_wack, 0);
        i_rreq[3] = 1'b1;
        tick();
        chk("c3_re", o_re, 1);
        chk("c3_raddr", o_addr, 3072);
        i_rreq = '0;
        tick();
        chk("c3_rvalid", o_rvalid, 10'h008);
        chk("c3_rdata", o_rdata, 8'hA5);
        tick();
        chk("c3_empty", o_empty[3], 1);

        // All writers requesting: strict order 0..9 then wrap to the next slot.
        do_reset();
        i_wreq = '1;
        for (int g = 0; g < 2*NCH; g++) begin
            wait_wack(ch, n);
            chk("rr_ch", ch, g % NCH);
            chk("rr_addr", o_addr, (g % NCH)*DEPTH + g / NCH);
            chk("rr_gap", n, (g == 0) ? 1 : 3);
        end

        // Reset during READ discards the read.
        i_wreq = '0;
        i_rreq[5] = 1'b1;
        wait_re(n);
        i_rst = 1'b0;
        mon_en = 0;
        i_rreq = '0;
        #1;
        chk("rstrd_re", o_re, 0);
        chk("rstrd_rvalid", o_rvalid, 0);
        chk("rstrd_empty", o_empty, 10'h3FF);
        repeat (2) tick();
        i_rst = 1'b1;
        model_reset();
        mon_en = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstrd_no_rvalid", o_rvalid, 0);
        end

        // Random traffic against the queue model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!i_wreq[c]) i_wreq[c] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) i_wreq[c] = 1'b0;
                i_rreq[c] = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        i_wreq = '0; i_rreq = '0;
        repeat (10) tick();
        chk("rand_writes", (n_wr > 100), 1);
        chk("rand_reads", (n_rd > 50), 1);

        // Fill channel 0 to capacity.
        do_reset();
        i_wreq[0] = 1'b1;
        cnt = 0;
        while (wcnt[0] < DEPTH && cnt < 3400) begin
            tick(); cnt++;
        end
        chk("fill_count", wcnt[0], DEPTH);
        tick();
        chk("fill_full", o_full[0], 1);
`ifdef UART_RAM_ARBITER_DROP_EN
        wait_wack(ch, n);
        chk("drop_ch", ch, 0);
        chk("drop_we", o_we, 0);
        tick();
        chk("drop_ovf", o_ovf[0], 1);
        chk("drop_full", o_full[0], 1);
        i_wreq = '0;
        repeat (3) tick();
        chk("drop_ovf_sticky", o_ovf[0], 1);
`else
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_wack[0]) cnt++;
        end
        chk("full_stall", cnt, 0);
        i_rreq[0] = 1'b1;
        wait_re(n);
        i_rreq = '0;
        chk("full_raddr", o_addr, 0);
        wait_wack(ch, n);
        chk("wrap_ch", ch, 0);
        chk("wrap_addr", o_addr, 0);
        i_wreq = '0;
        repeat (3) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
